pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Owns the fetch-stage program counter register and sequences the next-PC selection for the 5-stage pipeline.
- Each cycle it chooses between sequential PC+4 and the execute-stage branch/jump target.
- Honours the hazard unit's fetch stall and generates decode/execute flushes on redirect.
- Adds a boot delay after reset and a halt/resume handshake for debug. Replaces the free-standing PC register and next-PC mux pairing.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset and held during boot.
- BOOT_DELAY, 2, cycles after reset release before the first valid fetch. Legal range is 1..15.
- CNT_W, 16, width of the redirect event counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- stall_f  input  1  fetch stall from the hazard unit; holds the PC.
- pc_src_e  input  1  taken branch or jump resolved in execute.
- pc_target_e  input  32  branch/jump target from execute.
- halt_req  input  1  debug request to stop fetching; level-sensitive.
- resume  input  1  debug request to restart fetching; single-cycle pulse.
- pc_f  output  32  current fetch PC; registered.
- pc_plus4_f  output  32  pc_f + 4; combinational.
- fetch_valid  output  1  instruction fetched at pc_f is valid this cycle.
- flush_d  output  1  flush IF/ID register; combinational.
- flush_e  output  1  flush ID/EX register; combinational. The hazard unit ORs this with its load-use flush.
- halted  output  1  high while in HALT.
- redirect_count  output  CNT_W  number of redirects taken, saturating.

Behaviour:
- Reset values: pc_f=RESET_VECTOR, state=BOOT, boot counter=0, redirect_count=0. All other outputs are low during reset.
- States:
  - BOOT:
    - pc_f held; fetch_valid=0; flush_d=flush_e=0.
    - pc_src_e and halt_req are ignored.
    - Counter increments every cycle. When counter==BOOT_DELAY-1, go to RUN next cycle.
  - RUN:
    - fetch_valid=1.
    - Next PC priority: pc_src_e, then stall_f, then sequential.
      - pc_src_e=1: pc_f <= pc_target_e; flush_d=flush_e=1 in the same cycle; redirect_count++.
      - Else stall_f=1: pc_f holds.
      - Else: pc_f <= pc_plus4_f.
    - A redirect overrides stall_f.
    - halt_req=1: go to HALT next cycle. A redirect in the same cycle is still taken first, so a resume restarts at the target.
  - HALT:
    - fetch_valid=0; halted=1; pc_f held.
    - pc_src_e is still honoured, because in-flight instructions drain: pc_f <= pc_target_e, flushes asserted, counter incremented.
    - resume=1 and halt_req=0: go to RUN next cycle.
    - resume and halt_req both high: stay in HALT.
- Arithmetic: pc_plus4_f = pc_f + 4, modulo 2^32. 32'hFFFF_FFFC wraps to 32'h0000_0000.
- redirect_count saturates at all-ones and does not wrap.
- Reset asserted mid-operation, in any state, returns immediately to BOOT with all reset values. The boot delay restarts after reset is released.
- halted, fetch_valid and pc_f are all registered-state driven, so no combinational path from halt_req to them.
- The flush outputs are combinational from pc_src_e and state only.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - Adds output misalign_err (1 bit).
  - A redirect with pc_target_e[1:0]!=2'b00 is suppressed: pc_f holds, or advances if stall_f=0 as in the normal sequential case.
  - redirect_count is not incremented.
  - flush_d and flush_e are still asserted.
  - misalign_err pulses high for exactly one cycle, on the cycle after the event; reset value 0.
- Not defined:
  - No misalign_err port.
  - pc_target_e is loaded verbatim, including its low bits.

Test Plan:
- Reset with BOOT_DELAY=2, RESET_VECTOR=32'h100, then release -> fetch_valid=0 for 2 cycles with pc_f=32'h100, then fetch_valid=1 and pc_f steps 32'h104, 32'h108.
- In RUN at pc_f=32'h200, assert stall_f for 3 cycles -> pc_f stays 32'h200 for 3 cycles, then 32'h204.
- pc_src_e=1 with pc_target_e=32'h400 and stall_f=1 in the same cycle -> flush_d=flush_e=1 that cycle; next pc_f=32'h400; redirect_count increments by 1.
- halt_req asserted in the same cycle as a redirect to 32'h80 -> next cycle halted=1, fetch_valid=0, pc_f=32'h80. A resume pulse -> fetch_valid=1 at 32'h80, then 32'h84.
- Start at pc_f=32'hFFFF_FFFC, no stall -> next pc_f=32'h0. Force redirect_count to all-ones, then redirect -> count remains all-ones.
- With PC_ALIGN_CHECK_EN defined, redirect to 32'h302 at pc_f=32'h300 -> pc_f=32'h304, misalign_err=1 for one cycle, count unchanged, flushes asserted.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage program counter and next-PC sequencing for the
// 5-stage pipeline. It selects between sequential PC+4 and the execute-stage
// redirect target, honours the hazard unit's fetch stall, raises decode/execute
// flushes on redirect, holds fetch for a boot delay after reset, and supports a
// debug halt/resume handshake.
//
// Parameters:
//   RESET_VECTOR  PC loaded on reset and held during boot
//   BOOT_DELAY    cycles after reset release before the first valid fetch (1..15)
//   CNT_W         width of the saturating redirect counter
//
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   stall_f         fetch stall, holds the PC
//   pc_src_e        taken branch/jump resolved in execute
//   pc_target_e     redirect target from execute
//   halt_req        debug halt request (level)
//   resume          debug resume request (pulse)
//   pc_f            current fetch PC (registered)
//   pc_plus4_f      pc_f + 4 (combinational)
//   fetch_valid     fetch at pc_f is valid this cycle (registered)
//   flush_d/e       IF/ID and ID/EX flush (combinational)
//   halted          high while halted (registered)
//   redirect_count  number of redirects taken, saturating
//
// Optional build macro PC_ALIGN_CHECK_EN: adds misalign_err; redirects to a
// target with nonzero low bits are suppressed (flushes still raised) and
// reported by a one-cycle misalign_err pulse on the following cycle.

module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned BOOT_DELAY   = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_f,
    input  logic             pc_src_e,
    input  logic [31:0]      pc_target_e,
    input  logic             halt_req,
    input  logic             resume,
    output logic [31:0]      pc_f,
    output logic [31:0]      pc_plus4_f,
    output logic             fetch_valid,
    output logic             flush_d,
    output logic             flush_e,
    output logic             halted,
    output logic [CNT_W-1:0] redirect_count
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic             misalign_err
`endif
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [3:0] BOOT_LAST = 4'(BOOT_DELAY - 1);

    state_t     state;
    logic [3:0] boot_cnt;
    logic       redirect_live;
    logic       target_ok;
    logic       take_redirect;

    assign pc_plus4_f = pc_f + 32'd4;

    // Redirects are ignored only while booting; in HALT in-flight
    // instructions still drain and may redirect.
    assign redirect_live = pc_src_e && (state != BOOT);
    assign flush_d       = redirect_live;
    assign flush_e       = redirect_live;

`ifdef PC_ALIGN_CHECK_EN
    assign target_ok = (pc_target_e[1:0] == 2'b00);
`else
    assign target_ok = 1'b1;
`endif

    assign take_redirect = redirect_live && target_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= BOOT;
            boot_cnt       <= '0;
            pc_f           <= RESET_VECTOR;
            fetch_valid    <= 1'b0;
            halted         <= 1'b0;
            redirect_count <= '0;
`ifdef PC_ALIGN_CHECK_EN
            misalign_err   <= 1'b0;
`endif
        end else begin
            // Next PC: redirect beats stall; sequential advance only in RUN.
            // A suppressed (misaligned) redirect falls through to this
            // normal sequential choice.
            if (take_redirect) begin
                pc_f <= pc_target_e;
            end else if ((state == RUN) && !stall_f) begin
                pc_f <= pc_plus4_f;
            end

            if (take_redirect && (redirect_count != '1)) begin
                redirect_count <= redirect_count + CNT_W'(1);
            end

`ifdef PC_ALIGN_CHECK_EN
            misalign_err <= redirect_live && !target_ok;
`endif

            case (state)
                BOOT: begin
                    boot_cnt <= boot_cnt + 4'd1;
                    if (boot_cnt == BOOT_LAST) begin
                        state       <= RUN;
                        fetch_valid <= 1'b1;
                    end
                end
                RUN: begin
                    if (halt_req) begin
                        state       <= HALT;
                        fetch_valid <= 1'b0;
                        halted      <= 1'b1;
                    end
                end
                HALT: begin
                    if (resume && !halt_req) begin
                        state       <= RUN;
                        fetch_valid <= 1'b1;
                        halted      <= 1'b0;
                    end
                end
                default: begin
                    state       <= BOOT;
                    boot_cnt    <= '0;
                    fetch_valid <= 1'b0;
                    halted      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a table of per-cycle vectors (inputs
// plus the outputs expected before the clock edge) followed by hand-written
// sequences for mid-operation reset and counter saturation.

module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall_f = 1'b0;
    logic        pc_src_e = 1'b0;
    logic [31:0] pc_target_e = '0;
    logic        halt_req = 1'b0;
    logic        resume = 1'b0;
    logic [31:0] pc_f;
    logic [31:0] pc_plus4_f;
    logic        fetch_valid;
    logic        flush_d;
    logic        flush_e;
    logic        halted;
    logic [15:0] redirect_count;

    // Second instance: tiny counter for saturation, shortest boot delay.
    logic        s_src = 1'b0;
    logic [31:0] s_tgt = '0;
    logic [31:0] s_pc;
    logic [31:0] s_plus4;
    logic        s_valid;
    logic        s_flush_d;
    logic        s_flush_e;
    logic        s_halted;
    logic [1:0]  s_count;

`ifdef PC_ALIGN_CHECK_EN
    logic        misalign_err;
    logic        s_misalign;
`endif

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    pc_sequencer #(
        .RESET_VECTOR (32'h0000_0100),
        .BOOT_DELAY   (2),
        .CNT_W        (16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall_f        (stall_f),
        .pc_src_e       (pc_src_e),
        .pc_target_e    (pc_target_e),
        .halt_req       (halt_req),
        .resume         (resume),
        .pc_f           (pc_f),
        .pc_plus4_f     (pc_plus4_f),
        .fetch_valid    (fetch_valid),
        .flush_d        (flush_d),
        .flush_e        (flush_e),
        .halted         (halted),
        .redirect_count (redirect_count)
`ifdef PC_ALIGN_CHECK_EN
        ,
        .misalign_err   (misalign_err)
`endif
    );

    pc_sequencer #(
        .RESET_VECTOR (32'h0000_0000),
        .BOOT_DELAY   (1),
        .CNT_W        (2)
    ) u_sat (
        .clk            (clk),
        .reset          (reset),
        .stall_f        (1'b0),
        .pc_src_e       (s_src),
        .pc_target_e    (s_tgt),
        .halt_req       (1'b0),
        .resume         (1'b0),
        .pc_f           (s_pc),
        .pc_plus4_f     (s_plus4),
        .fetch_valid    (s_valid),
        .flush_d        (s_flush_d),
        .flush_e        (s_flush_e),
        .halted         (s_halted),
        .redirect_count (s_count)
`ifdef PC_ALIGN_CHECK_EN
        ,
        .misalign_err   (s_misalign)
`endif
    );

    typedef struct {
        logic        stall;
        logic        src;
        logic [31:0] tgt;
        logic        halt;
        logic        res;
        logic [31:0] pc;
        logic        valid;
        logic        hlt;
        logic        flush;
        logic [15:0] cnt;
        logic        mis;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic st, input logic src, input logic [31:0] tgt,
                       input logic hr, input logic rs, input logic [31:0] pc,
                       input logic vl, input logic hl, input logic fl,
                       input logic [15:0] cnt, input logic mis);
        vec_t v;
        v.stall = st; v.src = src; v.tgt = tgt; v.halt = hr; v.res = rs;
        v.pc = pc; v.valid = vl; v.hlt = hl; v.flush = fl; v.cnt = cnt; v.mis = mis;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_main(input string tag, input logic [31:0] pc, input logic vl,
                              input logic hl, input logic fl, input logic [15:0] cnt);
        check({tag, " pc_f"}, pc_f, pc);
        check({tag, " pc_plus4_f"}, pc_plus4_f, pc + 32'd4);
        check({tag, " fetch_valid"}, {31'd0, fetch_valid}, {31'd0, vl});
        check({tag, " halted"}, {31'd0, halted}, {31'd0, hl});
        check({tag, " flush_d"}, {31'd0, flush_d}, {31'd0, fl});
        check({tag, " flush_e"}, {31'd0, flush_e}, {31'd0, fl});
        check({tag, " redirect_count"}, {16'd0, redirect_count}, {16'd0, cnt});
    endtask

    initial begin
        // stall src target halt resume | pc valid halted flush count mis
        add(0, 1, 32'h0000_0999, 1, 0, 32'h0000_0100, 0, 0, 0, 16'd0, 0); // boot ignores redirect/halt
        add(0, 0, 32'h0, 0, 0, 32'h0000_0100, 0, 0, 0, 16'd0, 0);
        add(0, 0, 32'h0, 0, 0, 32'h0000_0100, 1, 0, 0, 16'd0, 0); // first valid fetch
        add(0, 0, 32'h0, 0, 0, 32'h0000_0104, 1, 0, 0, 16'd0, 0);
        add(0, 0, 32'h0, 0, 0, 32'h0000_0108, 1, 0, 0, 16'd0, 0);
        add(0, 1, 32'h0000_0200, 0, 0, 32'h0000_010C, 1, 0, 1, 16'd0, 0);
        add(1, 0, 32'h0, 0, 0, 32'h0000_0200, 1, 0, 0, 16'd1, 0); // stall x3
        add(1, 0, 32'h0, 0, 0, 32'h0000_0200, 1, 0, 0, 16'd1, 0);
        add(1, 0, 32'h0, 0, 0, 32'h0000_0200, 1, 0, 0, 16'd1, 0);
        add(0, 0, 32'h0, 0, 0, 32'h0000_0200, 1, 0, 0, 16'd1, 0);
        add(1, 1, 32'h0000_0400, 0, 0, 32'h0000_0204, 1, 0, 1, 16'd1, 0); // redirect beats stall
        add(0, 0, 32'h0, 0, 0, 32'h0000_0400, 1, 0, 0, 16'd2, 0);
        add(0, 1, 32'h0000_0080, 1, 0, 32'h0000_0404, 1, 0, 1, 16'd2, 0); // halt + redirect
        add(0, 0, 32'h0, 1, 0, 32'h0000_0080, 0, 1, 0, 16'd3, 0);
        add(0, 0, 32'h0, 1, 1, 32'h0000_0080, 0, 1, 0, 16'd3, 0); // resume with halt_req: stay
        add(1, 1, 32'h0000_0090, 1, 0, 32'h0000_0080, 0, 1, 1, 16'd3, 0); // redirect drains in HALT
        add(0, 0, 32'h0, 0, 1, 32'h0000_0090, 0, 1, 0, 16'd4, 0);
        add(0, 0, 32'h0, 0, 0, 32'h0000_0090, 1, 0, 0, 16'd4, 0);
        add(0, 1, 32'hFFFF_FFFC, 0, 0, 32'h0000_0094, 1, 0, 1, 16'd4, 0);
        add(0, 0, 32'h0, 0, 0, 32'hFFFF_FFFC, 1, 0, 0, 16'd5, 0);
        add(0, 0, 32'h0, 0, 0, 32'h0000_0000, 1, 0, 0, 16'd5, 0); // wrapped
        add(0, 1, 32'h0000_0302, 0, 0, 32'h0000_0004, 1, 0, 1, 16'd5, 0);
`ifdef PC_ALIGN_CHECK_EN
        add(0, 0, 32'h0, 0, 0, 32'h0000_0008, 1, 0, 0, 16'd5, 1); // suppressed, pulse
        add(0, 0, 32'h0, 0, 0, 32'h0000_000C, 1, 0, 0, 16'd5, 0);
`else
        add(0, 0, 32'h0, 0, 0, 32'h0000_0302, 1, 0, 0, 16'd6, 0); // low bits kept
        add(0, 0, 32'h0, 0, 0, 32'h0000_0306, 1, 0, 0, 16'd6, 0);
`endif

        // Reset state, with a redirect request present to show flushes stay low.
        pc_src_e = 1'b1;
        pc_target_e = 32'h0000_0777;
        repeat (2) @(posedge clk);
        #1;
        check_main("reset", 32'h0000_0100, 1'b0, 1'b0, 1'b0, 16'd0);
`ifdef PC_ALIGN_CHECK_EN
        check("reset misalign_err", {31'd0, misalign_err}, 32'd0);
`endif
        pc_src_e = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            stall_f     = vq[i].stall;
            pc_src_e    = vq[i].src;
            pc_target_e = vq[i].tgt;
            halt_req    = vq[i].halt;
            resume      = vq[i].res;
            #1;
            check_main($sformatf("vec%0d", i), vq[i].pc, vq[i].valid, vq[i].hlt,
                       vq[i].flush, vq[i].cnt);
`ifdef PC_ALIGN_CHECK_EN
            check($sformatf("vec%0d misalign_err", i), {31'd0, misalign_err}, {31'd0, vq[i].mis});
`endif
            if (i == 0) check("sat boot valid0", {31'd0, s_valid}, 32'd0);
            if (i == 1) check("sat boot valid1", {31'd0, s_valid}, 32'd1);
            @(posedge clk);
            @(negedge clk);
        end

        // Asynchronous reset mid-run: takes effect without a clock edge.
        stall_f = 1'b0; halt_req = 1'b0; resume = 1'b0;
        pc_src_e = 1'b1;
        pc_target_e = 32'h0000_0500;
        #2;
        reset = 1'b1;
        #1;
        check_main("async reset", 32'h0000_0100, 1'b0, 1'b0, 1'b0, 16'd0);
        @(negedge clk);
        reset = 1'b0;
        pc_src_e = 1'b0;
        #1;
        check_main("reboot c0", 32'h0000_0100, 1'b0, 1'b0, 1'b0, 16'd0);
        @(negedge clk); #1;
        check_main("reboot c1", 32'h0000_0100, 1'b0, 1'b0, 1'b0, 16'd0);
        @(negedge clk); #1;
        check_main("reboot c2", 32'h0000_0100, 1'b1, 1'b0, 1'b0, 16'd0);
        @(negedge clk); #1;
        check_main("reboot c3", 32'h0000_0104, 1'b1, 1'b0, 1'b0, 16'd0);

        // Saturation on the 2-bit counter instance.
        @(negedge clk);
        s_src = 1'b1;
        s_tgt = 32'h0000_0040;
        #1;
        check("sat count start", {30'd0, s_count}, 32'd0);
        check("sat flush", {31'd0, s_flush_d & s_flush_e}, 32'd1);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk); #1;
            check($sformatf("sat count %0d", k), {30'd0, s_count},
                  (k >= 3) ? 32'd3 : k);
            check($sformatf("sat pc %0d", k), s_pc, 32'h0000_0040);
        end
        s_src = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
